// File: rtl/gcd_display_pkg.sv
// Shared definitions for the GCD display stage: converter state encoding,
// active-low 7-segment patterns and the digit-to-segment decoder.
package gcd_defs;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SHIFT  = 2'b01,
    COMMIT = 2'b10
  } conv_state_e;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Non-decimal nibbles cannot occur after conversion; they fall back to blank.
  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/gcd_display_if.sv
// Connection between the GCD controller side (result + load level) and the
// display stage outputs.
interface gcd_display_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
);
  logic              gld;
  logic [WIDTH-1:0]  gcd;
  logic [6:0]        seg;
  logic [DIGITS-1:0] an;
  logic              busy;
  logic              valid;

  modport master (output gld, gcd, input seg, an, busy, valid);
  modport slave  (input gld, gcd, output seg, an, busy, valid);
endinterface

// File: rtl/gcd_display_bin2bcd.sv
// Sequential shift-add-3 binary to BCD converter; one shift per clock,
// result is held in bcd while done is high for the single COMMIT cycle.
module gcd_bin2bcd
  import gcd_defs::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  busy,
  output logic                  done
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);

  conv_state_e      state_r, state_n;
  logic [WIDTH-1:0] bin_r, bin_n;
  logic [BCD_W-1:0] bcd_r, bcd_n, adj_s;
  logic [CNT_W-1:0] cnt_r, cnt_n;
  logic             busy_r, busy_n;

  // Add-3 correction on every nibble that would overflow a decimal digit when doubled.
  always_comb begin
    adj_s = bcd_r;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_r[4*i +: 4] >= 4'd5) begin
        adj_s[4*i +: 4] = bcd_r[4*i +: 4] + 4'd3;
      end else begin
        adj_s[4*i +: 4] = bcd_r[4*i +: 4];
      end
    end
  end

  // Next-state and datapath update for the converter FSM.
  always_comb begin
    state_n = state_r;
    bin_n   = bin_r;
    bcd_n   = bcd_r;
    cnt_n   = cnt_r;
    busy_n  = busy_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          bin_n   = bin;
          bcd_n   = {BCD_W{1'b0}};
          cnt_n   = CNT_W'(WIDTH);
          busy_n  = 1'b1;
          state_n = SHIFT;
        end else begin
          state_n = IDLE;
        end
      end
      SHIFT: begin
        {bcd_n, bin_n} = {adj_s[BCD_W-2:0], bin_r, 1'b0};
        cnt_n          = cnt_r - CNT_W'(1);
        if (cnt_r == CNT_W'(1)) begin
          state_n = COMMIT;
        end else begin
          state_n = SHIFT;
        end
      end
      COMMIT: begin
        busy_n  = 1'b0;
        state_n = IDLE;
      end
      default: begin
        busy_n  = 1'b0;
        state_n = IDLE;
      end
    endcase
  end

  // Converter state and datapath registers.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_r <= IDLE;
      bin_r   <= {WIDTH{1'b0}};
      bcd_r   <= {BCD_W{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_n;
      bin_r   <= bin_n;
      bcd_r   <= bcd_n;
      cnt_r   <= cnt_n;
      busy_r  <= busy_n;
    end
  end

  assign bcd  = bcd_r;
  assign busy = busy_r;
  assign done = (state_r == COMMIT);

endmodule

// File: rtl/gcd_display.sv
// GCD result display: captures the result on a gld rise, converts it to BCD
// and scans it onto an active-low multiplexed 7-segment display.
module gcd_display
  import gcd_defs::*;
#(
  parameter int WIDTH       = 8,
  parameter int DIGITS      = 3,
  parameter int REFRESH_DIV = 50000
) (
  input  logic          clk,
  input  logic          clr,
  gcd_display_if.slave  bus
);

  localparam int BCD_W  = 4 * DIGITS;
  localparam int SCAN_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int DIG_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic              gld_q_r;
  logic              start_s;
  logic              conv_busy_s;
  logic              conv_done_s;
  logic [BCD_W-1:0]  conv_bcd_s;
  logic [BCD_W-1:0]  disp_r;
  logic              valid_r;
  logic [SCAN_W-1:0] scan_r;
  logic [DIG_W-1:0]  dig_r;
  logic [DIG_W-1:0]  msd_s;
  logic [6:0]        seg_s, seg_r;
  logic [DIGITS-1:0] an_s, an_r;

  // A rise seen while the converter is busy is dropped, never queued.
  assign start_s = bus.gld & ~gld_q_r & ~conv_busy_s;

  gcd_bin2bcd #(
    .WIDTH  (WIDTH),
    .DIGITS (DIGITS)
  ) u_bin2bcd (
    .clk   (clk),
    .clr   (clr),
    .start (start_s),
    .bin   (bus.gcd),
    .bcd   (conv_bcd_s),
    .busy  (conv_busy_s),
    .done  (conv_done_s)
  );

  // Load-level edge detect, display register capture and valid flag.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      gld_q_r <= 1'b0;
      disp_r  <= {BCD_W{1'b0}};
      valid_r <= 1'b0;
    end else begin
      gld_q_r <= bus.gld;
      if (conv_done_s) begin
        disp_r  <= conv_bcd_s;
        valid_r <= 1'b1;
      end else if (start_s) begin
        valid_r <= 1'b0;
      end else begin
        valid_r <= valid_r;
      end
    end
  end

  // Refresh prescaler and digit index.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      scan_r <= {SCAN_W{1'b0}};
      dig_r  <= {DIG_W{1'b0}};
    end else if (scan_r == SCAN_W'(REFRESH_DIV - 1)) begin
      scan_r <= {SCAN_W{1'b0}};
      if (dig_r == DIG_W'(DIGITS - 1)) begin
        dig_r <= {DIG_W{1'b0}};
      end else begin
        dig_r <= dig_r + DIG_W'(1);
      end
    end else begin
      scan_r <= scan_r + SCAN_W'(1);
    end
  end

  // Most significant nonzero digit; stays 0 for a zero value so units still show.
  always_comb begin
    msd_s = {DIG_W{1'b0}};
    for (int j = 0; j < DIGITS; j++) begin
      if (disp_r[4*j +: 4] != 4'd0) begin
        msd_s = DIG_W'(j);
      end else begin
        msd_s = msd_s;
      end
    end
  end

  // Segment pattern and digit enable for the current scan position.
  always_comb begin
    an_s = ~(DIGITS'(1) << dig_r);
    if (!valid_r) begin
      seg_s = SEG_BLANK;
    end else if (dig_r > msd_s) begin
      seg_s = SEG_BLANK;
    end else begin
      seg_s = seg_decode(disp_r[{dig_r, 2'b00} +: 4]);
    end
  end

  // Registered display drive.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      seg_r <= SEG_BLANK;
      an_r  <= {DIGITS{1'b1}};
    end else begin
      seg_r <= seg_s;
      an_r  <= an_s;
    end
  end

  assign bus.seg   = seg_r;
  assign bus.an    = an_r;
  assign bus.busy  = conv_busy_s;
  assign bus.valid = valid_r;

endmodule

// File: tb/tb_gcd_display.sv
// Self-checking bench for gcd_display: directed and random results checked
// against a decimal-arithmetic model of latency, digits and scan order.
module tb_gcd_display;

  localparam int WIDTH  = 8;
  localparam int DIGITS = 3;
  localparam int RD     = 4;

  logic clk = 1'b0;
  logic clr;

  always #5 clk = ~clk;

  gcd_display_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

  gcd_display #(
    .WIDTH       (WIDTH),
    .DIGITS      (DIGITS),
    .REFRESH_DIV (RD)
  ) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;

  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected pattern of digit position i for value v, from decimal arithmetic.
  function automatic logic [6:0] exp_seg(input int v, input int i);
    int p = 1;
    for (int k = 0; k < i; k++) p = p * 10;
    if (i > 0 && v < p) return 7'h7F;
    return seg_tab[(v / p) % 10];
  endfunction

  // Raise gld before the next edge (E0); sample k is taken after edge E_k.
  task automatic convert(input int v, input bit toggle, output int lat, output int bcnt);
    bus.gcd = v[WIDTH-1:0];
    bus.gld = 1'b1;
    lat  = -1;
    bcnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.busy === 1'b1) bcnt++;
      if (bus.valid === 1'b1) begin
        lat = k;
        break;
      end
      if (toggle && k == 0) bus.gld = 1'b0;
      if (toggle && k == 2) bus.gld = 1'b1;
    end
  endtask

  task automatic check_display(input int v);
    int prev;
    int run;
    int changes;
    int idx;
    prev = -1;
    run = 0;
    changes = 0;
    @(negedge clk);
    chk("valid_hold", bus.valid, 1);
    for (int c = 0; c < 2 * DIGITS * RD; c++) begin
      idx = -1;
      for (int i = 0; i < DIGITS; i++) begin
        if (bus.an === ~(3'b001 << i)) idx = i;
      end
      chk("an_onehot", idx >= 0, 1);
      if (idx >= 0) chk($sformatf("seg_v%0d_d%0d", v, idx), bus.seg, exp_seg(v, idx));
      if (prev >= 0 && idx != prev) begin
        if (changes > 0) chk("an_period", run, RD);
        chk("an_order", idx, (prev + 1) % DIGITS);
        changes++;
        run = 1;
      end else begin
        run++;
      end
      prev = idx;
      @(negedge clk);
    end
    chk("an_changed", changes >= DIGITS, 1);
  endtask

  task automatic run_value(input int v);
    int lat;
    int bcnt;
    convert(v, 1'b0, lat, bcnt);
    bus.gld = 1'b0;
    chk($sformatf("latency_v%0d", v), lat, 9);
    chk($sformatf("busy_cycles_v%0d", v), bcnt, 9);
    chk("busy_after_commit", bus.busy, 0);
    check_display(v);
  endtask

  initial begin
    int vals[$];
    int lat;
    int bcnt;

    clr     = 1'b1;
    bus.gld = 1'b0;
    bus.gcd = '0;
    repeat (2) @(negedge clk);
    chk("rst_seg", bus.seg, 7'h7F);
    chk("rst_an", bus.an, 3'b111);
    chk("rst_busy", bus.busy, 0);
    chk("rst_valid", bus.valid, 0);
    clr = 1'b0;
    @(negedge clk);
    chk("first_an", bus.an, 3'b110);
    chk("first_seg", bus.seg, 7'h7F);

    vals = {6, 255, 0, 100, 123};
    for (int n = 0; n < 6; n++) vals.push_back(int'($urandom_range(0, 255)));
    foreach (vals[n]) run_value(vals[n]);

    // Extra rise during SHIFT must be ignored, and a held gld never retriggers.
    convert(37, 1'b1, lat, bcnt);
    chk("retrig_latency", lat, 9);
    chk("retrig_busy_cycles", bcnt, 9);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("held_gld_busy", bus.busy, 0);
      chk("held_gld_valid", bus.valid, 1);
    end
    bus.gld = 1'b0;
    check_display(37);

    // Reset in the middle of a conversion; gld held high redisplays afterwards.
    bus.gcd = 8'd200;
    bus.gld = 1'b1;
    repeat (4) @(negedge clk);
    chk("pre_clr_busy", bus.busy, 1);
    clr = 1'b1;
    #1;
    chk("clr_busy", bus.busy, 0);
    chk("clr_valid", bus.valid, 0);
    chk("clr_seg", bus.seg, 7'h7F);
    chk("clr_an", bus.an, 3'b111);
    @(negedge clk);
    clr = 1'b0;
    convert(200, 1'b0, lat, bcnt);
    bus.gld = 1'b0;
    chk("post_clr_latency", lat, 9);
    chk("post_clr_busy_cycles", bcnt, 9);
    check_display(200);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/gcd_display.md
# gcd_display

Output stage downstream of the GCD controller/datapath. When the controller's `gld` strobe rises, the block captures the finished GCD value and converts it to BCD with a sequential shift-add-3 (double-dabble) engine. It then drives a time-multiplexed, active-low 7-segment display with leading-zero blanking. It is the only consumer of the GCD result register and `gld`.

## Interface
- `WIDTH`, default 8: bit width of the GCD result.
- `DIGITS`, default 3: number of display digits. Must satisfy 10^DIGITS > 2^WIDTH−1.
- `REFRESH_DIV`, default 50000: clk cycles each digit is enabled. Must be ≥2.
- `clk` in 1: system clock, rising edge.
- `clr` in 1: asynchronous, active-high reset.
- `gld` in 1: result-load level from the controller. Stays high while the controller is in its done state.
- `gcd` in WIDTH: GCD result. Must be stable whenever `gld` is high.
- `seg` out 7: segments {g,f,e,d,c,b,a}, active-low.
- `an` out DIGITS: digit enables, one-hot active-low. `an[0]` is the units digit.
- `busy` out 1: conversion in progress.
- `valid` out 1: display holds a completed conversion.

## Operation
- Rising-edge detect on `gld`:
  - `gld_q` is a register, reset 0.
  - Start is `gld & ~gld_q`, taken only in IDLE.
- Converter FSM:
  - **IDLE**: on start, load `gcd` into the binary shift register, zero the BCD register, set bit counter = WIDTH, clear `valid`, set `busy`, go to SHIFT.
  - **SHIFT**: each cycle, add 3 to every BCD nibble ≥5, then shift {bcd, bin} left 1 and decrement the counter. When the counter reaches 1 on this cycle, go to COMMIT.
  - **COMMIT**: copy BCD into the display register, set `valid`, clear `busy`, go to IDLE.
- Start pulses while in SHIFT or COMMIT are ignored, with no restart. A `gld` that stays high never retriggers.
- The display register keeps its old value during a new conversion. `valid` is low from load until commit.
- Scan counter: counts 0..REFRESH_DIV−1. On terminal count, the digit index increments and wraps DIGITS−1 → 0.
- Segment output:
  - `valid`=0: `seg`=7'h7F (blank).
  - Blank any digit above the most significant nonzero digit. The units digit always shows, including for value 0.
  - Segment patterns for digits 0–9: 40, 79, 24, 30, 19, 12, 02, 78, 00, 10 (hex).
- BCD arithmetic: all nibble adds are 4-bit with no carry out. After WIDTH shifts every nibble is ≤9.

## Timing
- Reset values: `seg`=7'h7F, `an`=all ones, `busy`=0, `valid`=0, state IDLE, scan counter 0, digit index 0, display register 0.
- `seg` and `an` are registered. On the first edge after `clr` deasserts, `an`=~1 (units digit enabled).
- Latency, with E0 = the edge that samples the `gld` rise:
  - E0: load. `busy`=1 after E0.
  - E1..E_WIDTH: the shifts.
  - E_WIDTH+1: commit; `valid`=1 and `busy`=0.
  - The new digits appear on `seg` one edge after commit.
  - Total for WIDTH=8: `valid` rises 9 cycles after E0.
- Scan: `an` changes every REFRESH_DIV cycles. `seg` updates on the same edge as `an`.
- `clr` mid-conversion: returns immediately to reset values. The partially converted value is discarded. A `gld` still high after reset release is seen as a rise on the first edge where `gld_q`=0. That is intended: it redisplays the result.

## Structure
- Shared package/header `gcd_defs` holds:
  - Converter state encoding: IDLE=2'b00, SHIFT=2'b01, COMMIT=2'b10.
  - The ten active-low segment constants and SEG_BLANK=7'h7F.
- Sub-module `gcd_bin2bcd`:
  - Holds the sequential double-dabble FSM.
  - Ports: `clk`, `clr`, `start`, `bin`, `bcd`, `busy`, `done`.
  - `gcd_display` wraps it with the edge detect, display register, scan counter and segment decode.

## Test plan
- `gcd`=6, pulse `gld` high: 9 cycles after E0 `valid`=1. `an[0]` phase shows 7'h02; `an[1]` and `an[2]` phases show 7'h7F.
- `gcd`=255: the digits scan as units 7'h12, tens 7'h12, hundreds 7'h24. `busy` is high exactly 9 cycles.
- `gcd`=0: units phase shows 7'h40 and the other phases show 7'h7F. `gcd`=100: digits show 1, 0, 0, with no blanking of inner zeros.
- Start with `gcd`=37, then toggle `gld` low→high at E3: the extra rise is ignored, the result is 37, and `valid` rises at E9 only.
- Assert `clr` at E4 of a conversion: `busy`=0, `valid`=0, `seg`=7'h7F and `an`=all ones immediately. With `gld` still high after release, a new conversion starts and completes with the correct value.
- REFRESH_DIV=4, valid result 123: `an` cycles 110, 101, 011, 110…, each for 4 cycles, with `seg` = 3, 2, 1 respectively.
